// File: rtl/dec_pkg.sv
// Shared definitions for the decryption scheduler: channel tags, FSM encoding
// and the word-to-byte ratio helper.
package dec_pkg;

   localparam logic [1:0] CH_CAESAR  = 2'd0;
   localparam logic [1:0] CH_SCYTALE = 2'd1;
   localparam logic [1:0] CH_ZIGZAG  = 2'd2;
   localparam logic [1:0] CH_INVALID = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic int bytes_per_word(input int mst_dwidth, input int sys_dwidth);
      return mst_dwidth / sys_dwidth;
   endfunction

endpackage

// File: rtl/dec_word_serializer.sv
// Holds one input word and presents it MSB-byte-first; the byte index tracks
// progress so the owner knows when the final byte is being issued.
module dec_word_serializer
   import dec_pkg::*;
#(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8
) (
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic [MST_DWIDTH-1:0] i_word,
   input  logic                  i_advance,
   output logic [SYS_DWIDTH-1:0] o_byte,
   output logic                  o_last
);

   localparam int BYTES = bytes_per_word(MST_DWIDTH, SYS_DWIDTH);
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [MST_DWIDTH-1:0] r_shreg;
   logic [IDX_W-1:0]      r_idx;

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (i_load) begin
         r_idx <= '0;
      end else if (i_advance) begin
         r_idx <= r_idx + IDX_W'(1);
      end
   end

   // The shift register is pure data; a reset word is never observed before a load.
   always_ff @(posedge clk_sys) begin
      if (i_load) begin
         r_shreg <= i_word;
      end else if (i_advance) begin
         r_shreg <= r_shreg << SYS_DWIDTH;
      end
   end

   assign o_byte = r_shreg[MST_DWIDTH-1 -: SYS_DWIDTH];
   assign o_last = (r_idx == IDX_W'(BYTES - 1));

endmodule

// File: rtl/dec_sched.sv
// Scheduler from the tagged input word stream to the three decryption channels:
// handshake, per-channel byte serialization with busy stalls, counters and error flag.
module dec_sched
   import dec_pkg::*;
#(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic [MST_DWIDTH-1:0] word_i,
   input  logic [1:0]            word_sel_i,
   input  logic                  word_valid_i,
   output logic                  word_ready_o,
   input  logic [2:0]            busy_i,
   output logic [SYS_DWIDTH-1:0] data_o,
   output logic [2:0]            valid_o,
   input  logic                  clr_i,
   output logic                  err_o,
   output logic [CNT_WIDTH-1:0]  cnt0_o,
   output logic [CNT_WIDTH-1:0]  cnt1_o,
   output logic [CNT_WIDTH-1:0]  cnt2_o,
   output logic                  idle_o
);

   state_t                r_state;
   logic [1:0]            r_tag;
   logic [SYS_DWIDTH-1:0] r_data;
   logic [2:0]            r_valid;
   logic                  r_err;
   logic [CNT_WIDTH-1:0]  r_cnt0;
   logic [CNT_WIDTH-1:0]  r_cnt1;
   logic [CNT_WIDTH-1:0]  r_cnt2;

   logic                  w_load;
   logic                  w_advance;
   logic                  w_last;
   logic                  w_busy_sel;
   logic [SYS_DWIDTH-1:0] w_byte;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
      return 3'b001 << ch;
   endfunction

   // Only the latched channel's busy bit matters; the others are ignored.
   always_comb begin
      w_busy_sel = 1'b1;
      case (r_tag)
         CH_CAESAR:  w_busy_sel = busy_i[0];
         CH_SCYTALE: w_busy_sel = busy_i[1];
         CH_ZIGZAG:  w_busy_sel = busy_i[2];
         default:    w_busy_sel = 1'b1;
      endcase
   end

   assign w_load    = (r_state == IDLE) && word_valid_i && (word_sel_i != CH_INVALID);
   assign w_advance = (r_state == SEND) && !w_busy_sel;

   dec_word_serializer #(
      .MST_DWIDTH (MST_DWIDTH),
      .SYS_DWIDTH (SYS_DWIDTH)
   ) u_ser (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .i_load    (w_load),
      .i_word    (word_i),
      .i_advance (w_advance),
      .o_byte    (w_byte),
      .o_last    (w_last)
   );

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tag   <= CH_CAESAR;
         r_data  <= '0;
         r_valid <= '0;
         r_err   <= 1'b0;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
         r_cnt2  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_valid <= '0;
               if (word_valid_i) begin
                  if (word_sel_i == CH_INVALID) begin
                     r_err <= 1'b1;
                  end else begin
                     r_tag   <= word_sel_i;
                     r_state <= SEND;
                  end
               end
            end
            SEND: begin
               if (w_advance) begin
                  r_data  <= w_byte;
                  r_valid <= ch_onehot(r_tag);
                  if (w_last) begin
                     r_state <= IDLE;
                     case (r_tag)
                        CH_CAESAR:  r_cnt0 <= sat_inc(r_cnt0);
                        CH_SCYTALE: r_cnt1 <= sat_inc(r_cnt1);
                        CH_ZIGZAG:  r_cnt2 <= sat_inc(r_cnt2);
                        default:    ;
                     endcase
                  end
               end else begin
                  r_valid <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
         // Clear takes priority over a same-edge increment or error event.
         if (clr_i) begin
            r_err  <= 1'b0;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
            r_cnt2 <= '0;
         end
      end
   end

   assign word_ready_o = (r_state == IDLE);
   assign idle_o       = (r_state == IDLE);
   assign data_o       = r_data;
   assign valid_o      = r_valid;
   assign err_o        = r_err;
   assign cnt0_o       = r_cnt0;
   assign cnt1_o       = r_cnt1;
   assign cnt2_o       = r_cnt2;

endmodule

// File: tb/tb_dec_sched.sv
// Bench for dec_sched: a byte-queue reference model checked every cycle, plus a
// table of words and hand-written sequences for stalls, reset, saturation and clear.
module tb_dec_sched;

   localparam int MST   = 32;
   localparam int SYS   = 8;
   localparam int CW    = 16;
   localparam int BYTES = MST / SYS;

   logic           clk_sys = 1'b0;
   logic           rst_n;
   logic [MST-1:0] word_i;
   logic [1:0]     word_sel_i;
   logic           word_valid_i;
   logic           word_ready_o;
   logic [2:0]     busy_i;
   logic [SYS-1:0] data_o;
   logic [2:0]     valid_o;
   logic           clr_i;
   logic           err_o;
   logic [CW-1:0]  cnt0_o, cnt1_o, cnt2_o;
   logic           idle_o;

   always #5 clk_sys = ~clk_sys;

   dec_sched #(.MST_DWIDTH(MST), .SYS_DWIDTH(SYS), .CNT_WIDTH(CW)) dut (
      .clk_sys      (clk_sys),
      .rst_n        (rst_n),
      .word_i       (word_i),
      .word_sel_i   (word_sel_i),
      .word_valid_i (word_valid_i),
      .word_ready_o (word_ready_o),
      .busy_i       (busy_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .clr_i        (clr_i),
      .err_o        (err_o),
      .cnt0_o       (cnt0_o),
      .cnt1_o       (cnt1_o),
      .cnt2_o       (cnt2_o),
      .idle_o       (idle_o)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Reference model: every accepted word becomes BYTES pending byte transfers.
   typedef struct packed {
      logic [1:0]     ch;
      logic [SYS-1:0] b;
      logic           last;
   } xfer_t;

   xfer_t          q[$];
   logic [SYS-1:0] m_data;
   logic [2:0]     m_valid;
   logic           m_err;
   logic [CW-1:0]  m_cnt[3];
   logic           m_acc;

   typedef struct {
      logic [MST-1:0] word;
      logic [1:0]     sel;
      logic           err;
      logic [CW-1:0]  c0, c1, c2;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      xfer_t x;
      m_acc = 1'b0;
      if (!rst_n) begin
         q.delete();
         m_data  = '0;
         m_valid = '0;
         m_err   = 1'b0;
         for (int c = 0; c < 3; c++) m_cnt[c] = '0;
      end else begin
         m_valid = '0;
         if (q.size() > 0) begin
            if (!busy_i[q[0].ch]) begin
               x       = q.pop_front();
               m_data  = x.b;
               m_valid = 3'b001 << x.ch;
               if (x.last && m_cnt[x.ch] != {CW{1'b1}}) m_cnt[x.ch] = m_cnt[x.ch] + CW'(1);
            end
         end else if (word_valid_i) begin
            if (word_sel_i == 2'd3) begin
               m_err = 1'b1;
            end else begin
               m_acc = 1'b1;
               for (int k = 0; k < BYTES; k++) begin
                  x.ch   = word_sel_i;
                  x.b    = word_i[MST-1-SYS*k -: SYS];
                  x.last = (k == BYTES - 1);
                  q.push_back(x);
               end
            end
         end
         if (clr_i) begin
            m_err = 1'b0;
            for (int c = 0; c < 3; c++) m_cnt[c] = '0;
         end
      end
   endtask

   task automatic check_outputs();
      check("valid_o", 32'(valid_o), 32'(m_valid));
      check("data_o", 32'(data_o), 32'(m_data));
      check("word_ready_o", 32'(word_ready_o), 32'(q.size() == 0));
      check("idle_o", 32'(idle_o), 32'(q.size() == 0));
      check("err_o", 32'(err_o), 32'(m_err));
      check("cnt0_o", 32'(cnt0_o), 32'(m_cnt[0]));
      check("cnt1_o", 32'(cnt1_o), 32'(m_cnt[1]));
      check("cnt2_o", 32'(cnt2_o), 32'(m_cnt[2]));
      check("valid_onehot", 32'($countones(valid_o) <= 1), 32'd1);
   endtask

   task automatic cycle();
      @(posedge clk_sys);
      cyc++;
      model_edge();
      @(negedge clk_sys);
      check_outputs();
   endtask

   task automatic send_word(input logic [MST-1:0] w, input logic [1:0] s);
      word_i       = w;
      word_sel_i   = s;
      word_valid_i = 1'b1;
      cycle();
      word_valid_i = 1'b0;
      word_i       = $urandom;
      word_sel_i   = 2'($urandom_range(0, 3));
   endtask

   initial begin
      logic [SYS-1:0] got[BYTES];
      logic [MST-1:0] w;
      logic [2:0]     vseq[$];
      logic [1:0]     tags[3];
      int             nb, nlow, idx, acc_cyc[3], ok;

      rst_n = 1'b0; word_i = '0; word_sel_i = '0; word_valid_i = 1'b0;
      busy_i = '0; clr_i = 1'b0;
      m_data = '0; m_valid = '0; m_err = 1'b0;
      for (int c = 0; c < 3; c++) m_cnt[c] = '0;
      @(negedge clk_sys);
      cycle();
      cycle();
      check("reset_ready", 32'(word_ready_o), 32'd1);
      check("reset_data", 32'(data_o), 32'd0);
      rst_n = 1'b1;
      cycle();

      tbl[0] = '{32'hA1B2C3D4, 2'd1, 1'b0, 16'd0, 16'd1, 16'd0};
      tbl[1] = '{32'h0BADF00D, 2'd3, 1'b1, 16'd0, 16'd1, 16'd0};
      tbl[2] = '{32'hDEADBEEF, 2'd0, 1'b1, 16'd1, 16'd1, 16'd0};
      tbl[3] = '{32'h12345678, 2'd2, 1'b1, 16'd1, 16'd1, 16'd1};
      tbl[4] = '{32'hCAFEBABE, 2'd0, 1'b1, 16'd2, 16'd1, 16'd1};

      foreach (tbl[i]) begin
         nb = 0; nlow = 0;
         send_word(tbl[i].word, tbl[i].sel);
         if (!word_ready_o) nlow++;
         for (int c = 0; c < BYTES; c++) begin
            cycle();
            if (!word_ready_o) nlow++;
            if (valid_o != 3'b000) begin
               if (nb < BYTES) got[nb] = data_o;
               nb++;
            end
         end
         check("tbl_ready_low", 32'(nlow), (tbl[i].sel == 2'd3) ? 32'd0 : 32'(BYTES));
         check("tbl_nbytes", 32'(nb), (tbl[i].sel == 2'd3) ? 32'd0 : 32'(BYTES));
         if (tbl[i].sel != 2'd3 && nb == BYTES) begin
            w = tbl[i].word;
            for (int k = 0; k < BYTES; k++)
               check("tbl_byte", 32'(got[k]), 32'(w[MST-1-SYS*k -: SYS]));
         end
         check("tbl_err", 32'(err_o), 32'(tbl[i].err));
         check("tbl_cnt0", 32'(cnt0_o), 32'(tbl[i].c0));
         check("tbl_cnt1", 32'(cnt1_o), 32'(tbl[i].c1));
         check("tbl_cnt2", 32'(cnt2_o), 32'(tbl[i].c2));
      end

      clr_i = 1'b1;
      cycle();
      clr_i = 1'b0;
      check("clr_err", 32'(err_o), 32'd0);
      check("clr_cnt0", 32'(cnt0_o), 32'd0);

      // Stall on channel 2 after byte 0x22, with busy_i[0] toggling alongside.
      send_word(32'h11223344, 2'd2);
      cycle();
      check("stall_b0", 32'(data_o), 32'h11);
      cycle();
      check("stall_b1", 32'(data_o), 32'h22);
      busy_i = 3'b100;
      cycle();
      check("stall_v1", 32'(valid_o), 32'd0);
      busy_i = 3'b101;
      cycle();
      check("stall_v2", 32'(valid_o), 32'd0);
      busy_i = 3'b001;
      cycle();
      check("stall_b2", 32'(data_o), 32'h33);
      check("stall_b2_v", 32'(valid_o), 32'b100);
      busy_i = 3'b000;
      cycle();
      check("stall_b3", 32'(data_o), 32'h44);
      check("stall_cnt2", 32'(cnt2_o), 32'd1);

      // Back-to-back words on channels 0, 1, 2 with word_valid_i held high.
      clr_i = 1'b1;
      cycle();
      clr_i = 1'b0;
      tags[0] = 2'd0; tags[1] = 2'd1; tags[2] = 2'd2;
      idx = 0;
      word_i = $urandom; word_sel_i = tags[0]; word_valid_i = 1'b1;
      for (int c = 0; c < 3 * (BYTES + 1); c++) begin
         cycle();
         vseq.push_back(valid_o);
         if (m_acc && idx < 3) begin
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < 3) begin
               word_i = $urandom; word_sel_i = tags[idx];
            end else begin
               word_valid_i = 1'b0;
            end
         end
      end
      word_valid_i = 1'b0;
      check("b2b_accepts", 32'(idx), 32'd3);
      if (idx == 3) begin
         check("b2b_space01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(BYTES + 1));
         check("b2b_space12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(BYTES + 1));
      end
      ok = 1;
      foreach (vseq[i])
         if (vseq[i] !== ((i % (BYTES + 1) == 0) ? 3'b000 : (3'b001 << (i / (BYTES + 1))))) ok = 0;
      check("b2b_valid_seq", 32'(ok), 32'd1);
      check("b2b_cnt0", 32'(cnt0_o), 32'd1);
      check("b2b_cnt1", 32'(cnt1_o), 32'd1);
      check("b2b_cnt2", 32'(cnt2_o), 32'd1);

      // Reset in the middle of a word, after byte 2 has gone out.
      send_word(32'h55667788, 2'd1);
      nb = 0;
      for (int c = 0; c < 10 && nb < 3; c++) begin
         cycle();
         if (valid_o != 3'b000) nb++;
      end
      check("mid_bytes_seen", 32'(nb), 32'd3);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("mid_rst_ready", 32'(word_ready_o), 32'd1);
      check("mid_rst_valid", 32'(valid_o), 32'd0);
      check("mid_rst_cnt1", 32'(cnt1_o), 32'd0);
      send_word(32'h9ABCDEF0, 2'd1);
      cycle();
      check("mid_next_b0", 32'(data_o), 32'h9A);
      for (int c = 1; c < BYTES; c++) cycle();
      check("mid_next_cnt1", 32'(cnt1_o), 32'd1);

      // Saturation from a forced all-ones counter, then clear on a completion edge.
      force dut.r_cnt0 = {CW{1'b1}};
      m_cnt[0] = {CW{1'b1}};
      cycle();
      release dut.r_cnt0;
      cycle();
      send_word(32'h01020304, 2'd0);
      for (int c = 0; c < BYTES; c++) cycle();
      check("sat_cnt0", 32'(cnt0_o), 32'hFFFF);
      send_word(32'h05060708, 2'd0);
      for (int c = 0; c < BYTES - 1; c++) cycle();
      clr_i = 1'b1;
      cycle();
      clr_i = 1'b0;
      check("sat_clr_cnt0", 32'(cnt0_o), 32'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         word_i       = $urandom;
         word_valid_i = ($urandom_range(0, 2) != 0);
         word_sel_i   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         for (int b = 0; b < 3; b++) busy_i[b] = ($urandom_range(0, 3) == 0);
         clr_i        = ($urandom_range(0, 63) == 0);
         rst_n        = ($urandom_range(0, 199) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dec_sched.md
# dec_sched

Single-clock scheduler between the decryption input word stream and the three decryption channels (0 = Caesar, 1 = Scytale, 2 = ZigZag). It accepts tagged MST_DWIDTH-bit words over a valid/ready handshake and serializes each word MSB-byte-first to the tagged channel, stalling on that channel's busy flag. It rejects invalid tags with a sticky error and keeps per-channel completed-word counters for status readout.

## Interface
- MST_DWIDTH, 32, input word width; integer multiple of SYS_DWIDTH
- SYS_DWIDTH, 8, byte width delivered to channels
- CNT_WIDTH, 16, width of each per-channel word counter
- clk_sys  in  1  system clock; reset rst_n is synchronous, active-low, clock clk_sys
- rst_n  in  1  synchronous active-low reset
- word_i  in  MST_DWIDTH  input word
- word_sel_i  in  2  destination channel tag for word_i
- word_valid_i  in  1  word_i/word_sel_i valid
- word_ready_o  out  1  scheduler can accept a word this cycle
- busy_i  in  3  per-channel busy; bit n high = channel n cannot take a byte
- data_o  out  SYS_DWIDTH  byte to channels (shared bus)
- valid_o  out  3  one-hot byte strobe; bit n = data_o belongs to channel n
- clr_i  in  1  synchronous clear of counters and error flag
- err_o  out  1  sticky: a word with tag 3 was accepted
- cnt0_o, cnt1_o, cnt2_o  out  CNT_WIDTH each  completed words per channel, saturating
- idle_o  out  1  high in IDLE

## Operation
- BYTES = MST_DWIDTH/SYS_DWIDTH (4 by default). Byte k of a word is sent in order k = 0..BYTES-1, where byte 0 = word_i[MST_DWIDTH-1 -: SYS_DWIDTH].
- Reset: state IDLE, data_o=0, valid_o=0, err_o=0, all counters 0, word_ready_o=1, idle_o=1. Reset mid-word discards the word with no partial completion counted.
- FSM states: IDLE, SEND.
- IDLE: word_ready_o=1. Handshake occurs when word_valid_i && word_ready_o.
  - Tag 0..2: latch word and tag, set byte index to 0, go to SEND.
  - Tag 3: drop the word, set err_o=1, stay in IDLE. No data_o/valid_o activity.
  - valid_o=0 every IDLE cycle; data_o holds its last value.
- SEND: word_ready_o=0, idle_o=0.
  - Each cycle with busy_i[tag]=0: data_o <= current byte, valid_o <= one-hot(tag), index++.
  - Each cycle with busy_i[tag]=1: valid_o <= 0, index unchanged.
  - When the byte with index BYTES-1 is issued: cnt[tag]++ (saturating at all ones), go to IDLE.
- The tag is latched. Changes on word_sel_i/word_i during SEND are ignored. busy_i bits of other channels are ignored.
- clr_i: clears err_o and all counters next edge. If clr_i coincides with an increment or an error event, clear wins. clr_i does not affect the FSM or the datapath.
- valid_o is never multi-hot.

## Timing
- All outputs are registered. word_ready_o and idle_o are decoded from state only, with no combinational path from inputs.
- Word accepted at edge k leads to byte 0 on data_o/valid_o after edge k+1. With no stalls, bytes appear on consecutive cycles, the last after edge k+BYTES, with the counter updated at that same edge.
- FSM is in IDLE after edge k+BYTES. The next accept occurs at edge k+BYTES+1 at the earliest: throughput is one word per BYTES+1 cycles.
- Each busy cycle adds exactly one cycle of latency. busy asserted indefinitely causes an indefinite hold with no timeout.

## Structure
- Package dec_pkg holds:
  - channel constants CH_CAESAR=2'd0, CH_SCYTALE=2'd1, CH_ZIGZAG=2'd2, CH_INVALID=2'd3
  - FSM state encoding (IDLE, SEND)
  - function bytes_per_word(MST_DWIDTH, SYS_DWIDTH)
- One sub-module, dec_word_serializer: load/shift register plus byte index, with an advance enable and a last-byte flag. dec_sched owns the FSM, the handshake, the counters and the error flag.

## Test plan
- Reset, then word 0xA1B2C3D4 with tag 1 and busy_i=0. Required response:
  - data_o = A1, B2, C3, D4 on 4 consecutive cycles with valid_o=3'b010
  - cnt1_o=1, word_ready_o low for exactly 4 cycles
- Word 0x11223344 with tag 2, busy_i[2] high for 2 cycles after byte 0x22. Required response:
  - 0x33 delayed 2 cycles, valid_o=0 during the stall
  - busy_i[0] toggling meanwhile has no effect; cnt2_o=1
- Word with tag 3. Required response: err_o=1, no valid_o pulse, counters unchanged, next tag-0 word 0xDEADBEEF serialized normally. Then clr_i. Required response: err_o=0, cnt0_o=0.
- Back-to-back valid words with tags 0, 1, 2. Required response:
  - accepts spaced 5 cycles apart
  - valid_o sequence 001×4, idle, 010×4, idle, 100×4
  - cnt0/1/2_o = 1 each
- Assert rst_n low after byte 2 of a word. Required response: all outputs return to reset values, the counter is not incremented, and the next word is sent from byte 0.
- Preload cnt0 to 0xFFFF through 65535 words (or a forced counter value), then send one more tag-0 word. Required response: cnt0_o stays 0xFFFF. Then clr_i on the completion edge of a further tag-0 word. Required response: cnt0_o=0.
